// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: credits 0.5/1-yuan coins, vends or refunds, holds the result display.
// Optional inactivity refund in COLLECT is built when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
    parameter int unsigned PRICE          = 5,
    parameter int unsigned MAX_BAL        = 20,
    parameter int unsigned HOLD_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_5j,
    input  logic       coin_1y,
    input  logic       sel_btn,
    input  logic       cancel_btn,
    output logic [1:0] status,
    output logic [4:0] balance,
    output logic [4:0] change_out,
    output logic       dispense,
    output logic       coin_reject
);

    localparam int unsigned BAL_W  = 5;
    localparam int unsigned SUM_W  = 6;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Encoding doubles as the status code driven to the LED stage.
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_COLLECT  = 2'b10,
        S_REFUND   = 2'b01,
        S_DISPENSE = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [BAL_W-1:0]    balance_q, balance_d;
    logic [BAL_W-1:0]    change_q, change_d;
    logic                dispense_q, dispense_d;
    logic                reject_q, reject_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [1:0]          coin_val;
    logic                coin_any;
    logic                coin_ok;
    logic                holding;
    logic                hold_done;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    credit;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                activity;
    assign activity = coin_any | sel_btn | cancel_btn;
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    // Simultaneous coins add up (1 + 2 = 3); sum is one bit wider than balance so it never wraps.
    assign coin_val  = {coin_1y, coin_5j};
    assign coin_any  = |coin_val;
    assign sum       = SUM_W'(balance_q) + SUM_W'(coin_val);
    assign coin_ok   = coin_any && (sum <= SUM_W'(MAX_BAL));
    assign credit    = coin_ok ? sum : SUM_W'(balance_q);
    assign holding   = (state_q == S_DISPENSE) || (state_q == S_REFUND);
    assign hold_done = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            balance_q  <= '0;
            change_q   <= '0;
            dispense_q <= 1'b0;
            reject_q   <= 1'b0;
            hold_q     <= '0;
`ifdef VEND_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            change_q   <= change_d;
            dispense_q <= dispense_d;
            reject_q   <= reject_d;
            hold_q     <= hold_d;
`ifdef VEND_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Coins are credited before buttons are evaluated; cancel outranks select.
    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        change_d   = change_q;
        dispense_d = 1'b0;
        reject_d   = coin_any && (holding || !coin_ok);
        hold_d     = '0;
`ifdef VEND_TIMEOUT_EN
        tmo_d      = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                balance_d = BAL_W'(credit);
                if (coin_ok) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                balance_d = BAL_W'(credit);
                if (cancel_btn) begin
                    state_d   = S_REFUND;
                    change_d  = BAL_W'(credit);
                    balance_d = '0;
                end else if (sel_btn && (credit >= SUM_W'(PRICE))) begin
                    state_d    = S_DISPENSE;
                    dispense_d = 1'b1;
                    change_d   = BAL_W'(credit - SUM_W'(PRICE));
                    balance_d  = '0;
                end
`ifdef VEND_TIMEOUT_EN
                else if (!activity) begin
                    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = S_REFUND;
                        change_d  = balance_q;
                        balance_d = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
`endif
            end
            S_DISPENSE, S_REFUND: begin
                if (hold_done) begin
                    state_d  = S_IDLE;
                    change_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign status      = state_q;
    assign balance     = balance_q;
    assign change_out  = change_q;
    assign dispense    = dispense_q;
    assign coin_reject = reject_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with PRICE=5, MAX_BAL=20, HOLD_CYCLES=10, TIMEOUT_CYCLES=50.
module tb_vend_ctrl;

    logic       clk;
    logic       rst_n;
    logic       coin_5j;
    logic       coin_1y;
    logic       sel_btn;
    logic       cancel_btn;
    logic [1:0] status;
    logic [4:0] balance;
    logic [4:0] change_out;
    logic       dispense;
    logic       coin_reject;

    int checks = 0;
    int errors = 0;

    vend_ctrl #(
        .PRICE          (5),
        .MAX_BAL        (20),
        .HOLD_CYCLES    (10),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_5j     (coin_5j),
        .coin_1y     (coin_1y),
        .sel_btn     (sel_btn),
        .cancel_btn  (cancel_btn),
        .status      (status),
        .balance     (balance),
        .change_out  (change_out),
        .dispense    (dispense),
        .coin_reject (coin_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one cycle of pulses at a falling edge; returns on the next falling edge.
    task automatic pulse(input logic c5, input logic c1, input logic sel, input logic can);
        coin_5j    = c5;
        coin_1y    = c1;
        sel_btn    = sel;
        cancel_btn = can;
        @(negedge clk);
        coin_5j    = 1'b0;
        coin_1y    = 1'b0;
        sel_btn    = 1'b0;
        cancel_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status"}, 32'(status), 0);
        check({tag, "_balance"}, 32'(balance), 0);
        check({tag, "_change"}, 32'(change_out), 0);
        check({tag, "_dispense"}, 32'(dispense), 0);
        check({tag, "_reject"}, 32'(coin_reject), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        coin_5j    = 1'b0;
        coin_1y    = 1'b0;
        sel_btn    = 1'b0;
        cancel_btn = 1'b0;
        idle(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Buttons in IDLE do nothing.
        pulse(0, 0, 1, 0);
        check("idle_sel", 32'(status), 0);
        pulse(0, 0, 0, 1);
        check("idle_cancel", 32'(status), 0);

        // Three 1-yuan coins then buy.
        pulse(0, 1, 0, 0);
        check("buy_bal1", 32'(balance), 2);
        check("buy_st1", 32'(status), 2);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        check("buy_bal3", 32'(balance), 6);
        pulse(0, 0, 1, 0);
        check("buy_status", 32'(status), 3);
        check("buy_dispense", 32'(dispense), 1);
        check("buy_change", 32'(change_out), 1);
        check("buy_bal0", 32'(balance), 0);
        idle(1);
        check("buy_disp_once", 32'(dispense), 0);
        idle(8);
        check("buy_hold_last", 32'(status), 3);
        idle(1);
        check("buy_hold_end", 32'(status), 0);
        check("buy_change_clr", 32'(change_out), 0);

        // Insufficient credit, then cancel.
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        check("low_bal", 32'(balance), 2);
        pulse(0, 0, 1, 0);
        check("low_sel_status", 32'(status), 2);
        check("low_sel_disp", 32'(dispense), 0);
        check("low_sel_bal", 32'(balance), 2);
        pulse(0, 0, 0, 1);
        check("cancel_status", 32'(status), 1);
        check("cancel_change", 32'(change_out), 2);
        check("cancel_bal", 32'(balance), 0);
        idle(10);
        check("cancel_end", 32'(status), 0);
        check("cancel_change_clr", 32'(change_out), 0);

        // Balance limit at MAX_BAL.
        for (int i = 0; i < 9; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        check("max_bal19", 32'(balance), 19);
        pulse(0, 1, 0, 0);
        check("max_reject", 32'(coin_reject), 1);
        check("max_bal_keep", 32'(balance), 19);
        idle(1);
        check("max_reject_once", 32'(coin_reject), 0);
        pulse(1, 0, 0, 0);
        check("max_bal20", 32'(balance), 20);
        check("max_no_reject", 32'(coin_reject), 0);
        pulse(0, 0, 0, 1);
        check("max_refund", 32'(change_out), 20);
        idle(10);

        // Coin, select and cancel together: coin credited, cancel wins.
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        check("combo_bal4", 32'(balance), 4);
        pulse(1, 0, 1, 1);
        check("combo_status", 32'(status), 1);
        check("combo_change", 32'(change_out), 5);
        check("combo_disp", 32'(dispense), 0);
        check("combo_bal", 32'(balance), 0);
        // Coin during REFUND is rejected.
        pulse(1, 0, 0, 0);
        check("refund_reject", 32'(coin_reject), 1);
        check("refund_bal", 32'(balance), 0);
        idle(9);
        check("combo_end", 32'(status), 0);

        // Coin during DISPENSE, then asynchronous reset mid-hold.
        for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        check("disp2_status", 32'(status), 3);
        pulse(0, 1, 0, 0);
        check("disp_reject", 32'(coin_reject), 1);
        check("disp_reject_st", 32'(status), 3);
        idle(4);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check("post_rst_status", 32'(status), 0);

        // Both coins in one cycle count as 3.
        pulse(1, 1, 0, 0);
        check("both_bal", 32'(balance), 3);
        check("both_status", 32'(status), 2);
`ifdef VEND_TIMEOUT_EN
        idle(49);
        check("tmo_before", 32'(status), 2);
        idle(1);
        check("tmo_status", 32'(status), 1);
        check("tmo_change", 32'(change_out), 3);
        check("tmo_bal", 32'(balance), 0);
        idle(10);
`else
        idle(60);
        check("no_tmo_status", 32'(status), 2);
        check("no_tmo_bal", 32'(balance), 3);
        pulse(0, 0, 0, 1);
        check("no_tmo_change", 32'(change_out), 3);
        idle(10);
`endif
        check("final_status", 32'(status), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE, default 5, item price in 0.5-yuan units.
REQ-002 The block SHALL have parameter MAX_BAL, default 20, maximum balance in 0.5-yuan units (must be at most 31).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 100_000_000, result-display duration in clk cycles (2 s at 50 MHz).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1_500_000_000, inactivity timeout in clk cycles (30 s), used only under VEND_TIMEOUT_EN.
REQ-005 The block SHALL have the following ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- coin_5j  input  1  single-cycle pulse: 0.5-yuan coin inserted.
- coin_1y  input  1  single-cycle pulse: 1-yuan coin inserted.
- sel_btn  input  1  single-cycle pulse from debounced buy key.
- cancel_btn  input  1  single-cycle pulse from debounced cancel key.
- status  output  2  machine state code for the LED stage.
- balance  output  5  current credit in 0.5-yuan units.
- change_out  output  5  change or refund amount being returned.
- dispense  output  1  single-cycle vend strobe.
- coin_reject  output  1  single-cycle strobe: coin returned to customer.

Function
REQ-006 The FSM SHALL have states IDLE, COLLECT, DISPENSE and REFUND, with status encoded as IDLE=00, COLLECT=10, REFUND=01, DISPENSE=11.
REQ-007 All outputs SHALL be registered; the response to an input pulse SHALL appear on the next rising clk edge (1-cycle latency).
REQ-008 Coin values SHALL be coin_5j=1 and coin_1y=2; if both pulse in the same cycle, the coin total SHALL be 3.
REQ-009 In IDLE or COLLECT, a coin with balance+value<=MAX_BAL SHALL add value to balance and move IDLE to COLLECT.
REQ-010 In IDLE or COLLECT, a coin with balance+value>MAX_BAL SHALL pulse coin_reject once, leave balance unchanged, and reject any simultaneous coins together.
REQ-011 Balance arithmetic SHALL be performed 6 bits wide so that no sum wraps before the MAX_BAL compare.
REQ-012 In COLLECT, sel_btn with balance>=PRICE SHALL move to DISPENSE, pulse dispense once, load change_out=balance-PRICE, and clear balance.
REQ-013 In COLLECT, sel_btn with balance<PRICE SHALL be ignored.
REQ-014 In COLLECT, cancel_btn SHALL move to REFUND, load change_out=balance, and clear balance.
REQ-015 cancel_btn SHALL take priority over sel_btn when both pulse in the same cycle.
REQ-016 If a coin and a button pulse in the same cycle, the coin SHALL be credited first and the button evaluated against the updated balance.
REQ-017 sel_btn and cancel_btn SHALL be ignored in IDLE.
REQ-018 In DISPENSE and REFUND, buttons SHALL be ignored and each coin pulse SHALL produce a coin_reject pulse.
REQ-019 DISPENSE and REFUND SHALL each last exactly HOLD_CYCLES cycles, then return to IDLE with change_out cleared to 0.
REQ-020 The hold counter SHALL restart from 0 on every entry to DISPENSE or REFUND.

Reset
REQ-021 Asserting rst_n low at any time, including mid-hold, SHALL immediately force state=IDLE, status=00, balance=0, change_out=0, dispense=0, coin_reject=0, and clear all counters.
REQ-022 Credit SHALL be lost on reset, with no refund issued.

Configuration
REQ-023 With VEND_TIMEOUT_EN defined, a counter SHALL run in COLLECT, restart on every coin or button pulse, and force a REFUND of the full balance after TIMEOUT_CYCLES idle cycles.
REQ-024 Without VEND_TIMEOUT_EN, COLLECT SHALL hold indefinitely, no timeout counter SHALL be synthesised, and TIMEOUT_CYCLES SHALL be unused.

Verification
Benches use PRICE=5, MAX_BAL=20, HOLD_CYCLES=10, and TIMEOUT_CYCLES=50 where applicable.
REQ-025 Three coin_1y pulses then sel_btn -> balance=6, then status=11, dispense one cycle, change_out=1, balance=0; after 10 cycles status=00 and change_out=0.
REQ-026 coin_5j x2 then sel_btn -> sel ignored and status stays 10; cancel_btn -> status=01, change_out=2; after 10 cycles status=00.
REQ-027 Balance 19 then coin_1y -> coin_reject one cycle and balance stays 19; then coin_5j -> balance=20.
REQ-028 Balance 4, then coin_5j+sel_btn+cancel_btn in the same cycle -> REFUND with change_out=5 and no dispense.
REQ-029 Coin pulse during DISPENSE -> coin_reject; rst_n low at hold cycle 5 -> all outputs at reset values at once.
REQ-030 With VEND_TIMEOUT_EN defined: balance 3 and no activity for 50 cycles -> status=01, change_out=3.
